// File: rtl/button_conditioner.sv
// Push-button conditioner: per channel synchroniser, debounce,
// press/release strobes and hold-to-auto-repeat.

module button_channel #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic butt,
  output logic pressed,
  output logic push,
  output logic release_pulse
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD)
                      ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] D_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);
  localparam bit            RPT_ON  = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RPT
  } state_t;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          differ;

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic          push_n;
  logic          rel_n;

  // raw input is active-low, so it differs from the level when equal
  assign differ = (s2 == pressed);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      s1 <= butt;
      s2 <= s1;
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == D_LAST) begin
        cnt     <= '0;
        pressed <= ~pressed;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      push          <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      push          <= push_n;
      release_pulse <= rel_n;
    end
  end

  // a debounced release always takes priority over a repeat tick
  always_comb begin
    state_n = state;
    timer_n = timer;
    push_n  = 1'b0;
    rel_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pressed) begin
          push_n  = 1'b1;
          timer_n = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (!pressed) begin
          rel_n   = 1'b1;
          timer_n = '0;
          state_n = IDLE;
        end else if (RPT_ON && timer == RD_LAST) begin
          push_n  = 1'b1;
          timer_n = '0;
          state_n = RPT;
        end else if (timer != RD_LAST) begin
          timer_n = timer + TW'(1);
        end
      end
      RPT: begin
        if (!pressed) begin
          rel_n   = 1'b1;
          timer_n = '0;
          state_n = IDLE;
        end else if (timer == RP_LAST) begin
          push_n  = 1'b1;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

module button_conditioner #(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] butt,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] push,
  output logic [N_BUTTONS-1:0] release_pulse
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .butt         (butt[i]),
      .pressed      (pressed[i]),
      .push         (push[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: repeat-enabled and
// repeat-disabled instances share stimulus, checked every cycle.

module tb_button_conditioner;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] butt  = '1;

  logic [N-1:0] pressed_a, push_a, rel_a;
  logic [N-1:0] pressed_b, push_b, rel_b;

  always #5 clock = ~clock;

  button_conditioner #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_a (
    .clock(clock), .reset(reset), .butt(butt),
    .pressed(pressed_a), .push(push_a), .release_pulse(rel_a)
  );

  button_conditioner #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_b (
    .clock(clock), .reset(reset), .butt(butt),
    .pressed(pressed_b), .push(push_b), .release_pulse(rel_b)
  );

  typedef struct packed {
    logic [N-1:0] pr;
    logic [N-1:0] pu;
    logic [N-1:0] rl;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   mcyc   = 0;

  // reference model: delayed raw samples, run-length acceptance,
  // push times as offsets from the first push of a hold
  int cyc = 0;
  bit sh1[N];
  bit sh2[N];
  bit lvl[2][N];
  int run[2][N];
  bit held[2][N];
  int first[2][N];

  task automatic step(input logic [N-1:0] v, input bit rst);
    exp_t e;
    bit   d, p, pu, rl;
    int   dt;
    e = '0;
    for (int ch = 0; ch < N; ch++) begin
      if (rst) begin
        sh1[ch] = 1'b1;
        sh2[ch] = 1'b1;
        for (int i = 0; i < 2; i++) begin
          lvl[i][ch]  = 1'b0;
          run[i][ch]  = 0;
          held[i][ch] = 1'b0;
        end
      end else begin
        d       = sh2[ch];
        sh2[ch] = sh1[ch];
        sh1[ch] = v[ch];
        for (int i = 0; i < 2; i++) begin
          p  = lvl[i][ch];
          pu = 1'b0;
          rl = 1'b0;
          if (p && !held[i][ch]) begin
            pu          = 1'b1;
            held[i][ch] = 1'b1;
            first[i][ch] = cyc;
          end else if (p) begin
            dt = cyc - first[i][ch];
            if (i == 0 && (dt == RD || (dt > RD && (dt - RD) % RP == 0)))
              pu = 1'b1;
          end else if (held[i][ch]) begin
            rl          = 1'b1;
            held[i][ch] = 1'b0;
          end
          if ((d == 1'b0) != p) begin
            run[i][ch]++;
            if (run[i][ch] == D) begin
              lvl[i][ch] = !p;
              run[i][ch] = 0;
            end
          end else begin
            run[i][ch] = 0;
          end
          if (i == 0) begin
            e.a.pr[ch] = lvl[i][ch];
            e.a.pu[ch] = pu;
            e.a.rl[ch] = rl;
          end else begin
            e.b.pr[ch] = lvl[i][ch];
            e.b.pu[ch] = pu;
            e.b.rl[ch] = rl;
          end
        end
      end
    end
    cyc++;
    expq.push_back(e);
  endtask

  function automatic void chk(string nm, logic [N-1:0] act,
                              logic [N-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b want %b", nm, mcyc, act, want);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      mcyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pressed_rpt",   pressed_a, e.a.pr);
        chk("push_rpt",      push_a,    e.a.pu);
        chk("release_rpt",   rel_a,     e.a.rl);
        chk("pressed_norpt", pressed_b, e.b.pr);
        chk("push_norpt",    push_b,    e.b.pu);
        chk("release_norpt", rel_b,     e.b.rl);
      end
    end
  end

  task automatic tick(input logic [N-1:0] v);
    @(negedge clock);
    butt = v;
    step(v, !reset);
  endtask

  task automatic tick_rst(input logic [N-1:0] v, input logic r);
    logic [6*N-1:0] all;
    @(negedge clock);
    butt  = v;
    reset = r;
    if (!r) begin
      #1;
      all = {pressed_a, push_a, rel_a, pressed_b, push_b, rel_b};
      checks++;
      if (all !== '0) begin
        errors++;
        $display("FAIL reset_async: got %b want 0", all);
      end
    end
    step(v, !r);
  endtask

  task automatic hold(input logic [N-1:0] v, input int n);
    for (int k = 0; k < n; k++) tick(v);
  endtask

  initial begin
    int           rem[N];
    logic [N-1:0] v;

    // held through reset, then released
    for (int k = 0; k < 5; k++) tick_rst(2'b00, 1'b0);
    tick_rst(2'b00, 1'b1);
    hold(2'b00, 11);
    hold(2'b11, 10);

    // short glitch
    hold(2'b10, 3);
    hold(2'b11, 10);

    // long hold with repeats
    hold(2'b10, 30);
    hold(2'b11, 10);

    // bounce on channel 0, random activity on channel 1
    v = 2'b11;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) v[0] = ~v[0];
      v[1] = 1'($urandom_range(0, 1));
      tick(v);
    end
    v[0] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      v[1] = 1'($urandom_range(0, 1));
      tick(v);
    end
    hold(2'b11, 10);

    // reset while holding
    hold(2'b00, 12);
    for (int k = 0; k < 3; k++) tick_rst(2'b00, 1'b0);
    tick_rst(2'b00, 1'b1);
    hold(2'b00, 25);
    hold(2'b11, 10);

    // random runs
    for (int ch = 0; ch < N; ch++) rem[ch] = 0;
    v = 2'b11;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          v[ch]   = 1'($urandom_range(0, 1));
          rem[ch] = $urandom_range(1, 30);
        end
        rem[ch]--;
      end
      tick(v);
    end
    hold(2'b11, 10);

    @(posedge clock);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
